// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared encodings for the vending credit controller: coin codes
//            and values, product codes and prices, FSM states, change coins.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

   // Inserted-coin encodings
   localparam logic [1:0] c_COIN_NICKEL  = 2'b00;
   localparam logic [1:0] c_COIN_DIME    = 2'b01;
   localparam logic [1:0] c_COIN_QUARTER = 2'b10;
   localparam logic [1:0] c_COIN_DOLLAR  = 2'b11;

   // Coin values in cents
   localparam logic [7:0] c_VAL_NICKEL  = 8'd5;
   localparam logic [7:0] c_VAL_DIME    = 8'd10;
   localparam logic [7:0] c_VAL_QUARTER = 8'd25;
   localparam logic [7:0] c_VAL_DOLLAR  = 8'd100;

   // Product encodings (bit position of the matching vend line)
   localparam logic [1:0] c_PROD_APPLE  = 2'b00;
   localparam logic [1:0] c_PROD_BANANA = 2'b01;
   localparam logic [1:0] c_PROD_CARROT = 2'b10;
   localparam logic [1:0] c_PROD_DATE   = 2'b11;

   // Product prices in cents
   localparam logic [7:0] c_PRICE_APPLE  = 8'd75;
   localparam logic [7:0] c_PRICE_BANANA = 8'd20;
   localparam logic [7:0] c_PRICE_CARROT = 8'd30;
   localparam logic [7:0] c_PRICE_DATE   = 8'd40;

   // Change-coin encodings (dollar is never returned)
   localparam logic [1:0] c_CHG_NICKEL  = 2'b00;
   localparam logic [1:0] c_CHG_DIME    = 2'b01;
   localparam logic [1:0] c_CHG_QUARTER = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUY    = 2'd1,
      ST_CHANGE = 2'd2
   } state_t;

   function automatic logic [7:0] coin_value(input logic [1:0] code);
      logic [7:0] v;
      case (code)
         c_COIN_NICKEL:  v = c_VAL_NICKEL;
         c_COIN_DIME:    v = c_VAL_DIME;
         c_COIN_QUARTER: v = c_VAL_QUARTER;
         default:        v = c_VAL_DOLLAR;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] product_price(input logic [1:0] code);
      logic [7:0] p;
      case (code)
         c_PROD_APPLE:  p = c_PRICE_APPLE;
         c_PROD_BANANA: p = c_PRICE_BANANA;
         c_PROD_CARROT: p = c_PRICE_CARROT;
         default:       p = c_PRICE_DATE;
      endcase
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_sel.sv
`default_nettype none
// ============================================================================
// Module   : vend_change_sel
// Purpose  : Greedy change-coin chooser. Picks the largest of quarter, dime,
//            nickel not exceeding the given credit; o_valid is low when the
//            credit is below a nickel.
// Revision : 1.0 - initial release
// ============================================================================
module vend_change_sel
   import vend_pkg::*;
(
   input  logic [7:0] i_credit,
   output logic       o_valid,
   output logic [1:0] o_coin,
   output logic [7:0] o_value
);

   // Largest-coin-first selection
   always_comb begin
      o_valid = 1'b0;
      o_coin  = c_CHG_NICKEL;
      o_value = 8'd0;
      if (i_credit >= c_VAL_QUARTER) begin
         o_valid = 1'b1;
         o_coin  = c_CHG_QUARTER;
         o_value = c_VAL_QUARTER;
      end else if (i_credit >= c_VAL_DIME) begin
         o_valid = 1'b1;
         o_coin  = c_CHG_DIME;
         o_value = c_VAL_DIME;
      end else if (i_credit >= c_VAL_NICKEL) begin
         o_valid = 1'b1;
         o_coin  = c_CHG_NICKEL;
         o_value = c_VAL_NICKEL;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vend_credit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_credit_ctrl
// Purpose  : Coin credit accumulator and purchase sequencer in front of the
//            vending purchase manager. Collects coins, issues a buy strobe,
//            consumes the vend/error response and pays out change greedily.
// Revision : 1.0 - initial release
// ============================================================================
module vend_credit_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned MAX_CREDIT = 200,
   parameter int unsigned TIMEOUT    = 16
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       buy_req,
   input  logic [1:0] product_sel,
   input  logic       refund_req,
   input  logic       apple,
   input  logic       banana,
   input  logic       carrot,
   input  logic       date,
   input  logic       error,
   output logic [7:0] credit,
   output logic       buy,
   output logic [1:0] product,
   output logic       coin_reject,
   output logic       deny,
   output logic       change_valid,
   output logic [1:0] change_coin,
   output logic       busy
);

   localparam int unsigned         c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
   localparam logic [8:0]          c_MAX_SUM  = 9'(MAX_CREDIT);

   state_t               r_state;
   state_t               w_next_state;
   logic [7:0]           r_credit;
   logic [7:0]           w_next_credit;
   logic [1:0]           r_product;
   logic [1:0]           w_next_product;
   logic [c_TMO_W-1:0]   r_tmo;
   logic [c_TMO_W-1:0]   w_next_tmo;
   logic                 w_deny;
   logic                 w_reject;
   logic [8:0]           w_sum;
   logic [3:0]           w_vend;
   logic [3:0]           w_want;
   logic [7:0]           w_price;

   logic                 r_buy;
   logic                 r_busy;
   logic                 r_deny;
   logic                 r_reject;
   logic                 r_chg_valid;
   logic [1:0]           r_chg_coin;
   logic [7:0]           r_chg_value;

   logic                 w_sel_valid;
   logic [1:0]           w_sel_coin;
   logic [7:0]           w_sel_value;
   logic                 w_chg_issue;

   // Change coin for the credit that will be held next cycle, so the coin is
   // presented during the CHANGE cycle whose closing edge deducts it.
   vend_change_sel u_change_sel (
      .i_credit (w_next_credit),
      .o_valid  (w_sel_valid),
      .o_coin   (w_sel_coin),
      .o_value  (w_sel_value)
   );

   assign w_chg_issue = (w_next_state == ST_CHANGE) && w_sel_valid;

   // Next-state, next-credit and pulse decisions
   always_comb begin
      w_next_state   = r_state;
      w_next_credit  = r_credit;
      w_next_product = r_product;
      w_next_tmo     = r_tmo;
      w_deny         = 1'b0;
      w_reject       = coin_valid;
      w_sum          = {1'b0, r_credit} + {1'b0, coin_value(coin_type)};
      w_vend         = {date, carrot, banana, apple};
      w_want         = 4'b0001 << r_product;
      w_price        = product_price(r_product);

      case (r_state)
         ST_IDLE: begin
            w_next_tmo = '0;
            if (refund_req) begin
               if (r_credit != 8'd0) begin
                  w_next_state = ST_CHANGE;
               end
            end else if (buy_req) begin
               w_next_product = product_sel;
               w_next_state   = ST_BUY;
            end else if (coin_valid && (w_sum <= c_MAX_SUM)) begin
               w_next_credit = w_sum[7:0];
               w_reject      = 1'b0;
            end
         end

         ST_BUY: begin
            if ((w_vend != 4'b0000) || error) begin
               // Only the exact product line, with no error and enough credit,
               // counts as a vend; anything else is a failed purchase.
               if (!error && (w_vend == w_want) && (r_credit >= w_price)) begin
                  w_next_credit = r_credit - w_price;
                  w_next_state  = (r_credit == w_price) ? ST_IDLE : ST_CHANGE;
               end else begin
                  w_deny       = 1'b1;
                  w_next_state = ST_IDLE;
               end
            end else if (r_tmo == c_TMO_LAST) begin
               w_deny       = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               w_next_tmo = r_tmo + 1'b1;
            end
         end

         ST_CHANGE: begin
            if (r_chg_valid) begin
               w_next_credit = r_credit - r_chg_value;
               if (w_next_credit == 8'd0) begin
                  w_next_state = ST_IDLE;
               end
            end else begin
               // Sub-nickel residue cannot be paid out; discard it.
               w_next_credit = 8'd0;
               w_next_state  = ST_IDLE;
            end
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_credit    <= 8'd0;
         r_product   <= 2'b00;
         r_tmo       <= '0;
         r_buy       <= 1'b0;
         r_busy      <= 1'b0;
         r_deny      <= 1'b0;
         r_reject    <= 1'b0;
         r_chg_valid <= 1'b0;
         r_chg_coin  <= 2'b00;
         r_chg_value <= 8'd0;
      end else begin
         r_state     <= w_next_state;
         r_credit    <= w_next_credit;
         r_product   <= w_next_product;
         r_tmo       <= w_next_tmo;
         r_buy       <= (w_next_state == ST_BUY);
         r_busy      <= (w_next_state != ST_IDLE);
         r_deny      <= w_deny;
         r_reject    <= w_reject;
         r_chg_valid <= w_chg_issue;
         r_chg_coin  <= w_chg_issue ? w_sel_coin : 2'b00;
         r_chg_value <= w_chg_issue ? w_sel_value : 8'd0;
      end
   end

   assign credit       = r_credit;
   assign buy          = r_buy;
   assign product      = r_product;
   assign coin_reject  = r_reject;
   assign deny         = r_deny;
   assign change_valid = r_chg_valid;
   assign change_coin  = r_chg_coin;
   assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_credit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_credit_ctrl
// Purpose  : Directed bench for vend_credit_ctrl with a behavioural model of
//            the credit/purchase/change rules and a responder standing in for
//            the purchase manager.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_credit_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       buy_req;
   logic [1:0] product_sel;
   logic       refund_req;
   logic       apple, banana, carrot, date, error;
   logic [7:0] credit;
   logic       buy;
   logic [1:0] product;
   logic       coin_reject;
   logic       deny;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int resp_mode = 0;   // 0 silent, 1 correct vend, 2 error, 3 wrong vend line
   bit chk_en = 1'b0;

   vend_credit_ctrl #(.MAX_CREDIT(200), .TIMEOUT(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .buy_req      (buy_req),
      .product_sel  (product_sel),
      .refund_req   (refund_req),
      .apple        (apple),
      .banana       (banana),
      .carrot       (carrot),
      .date         (date),
      .error        (error),
      .credit       (credit),
      .buy          (buy),
      .product      (product),
      .coin_reject  (coin_reject),
      .deny         (deny),
      .change_valid (change_valid),
      .change_coin  (change_coin),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Purchase-manager stand-in: answers combinationally while buy is high
   logic [3:0] vend_lines;
   always_comb begin
      vend_lines = 4'b0000;
      error      = 1'b0;
      if (buy) begin
         case (resp_mode)
            1: vend_lines[product] = 1'b1;
            2: error = 1'b1;
            3: vend_lines[product + 2'd1] = 1'b1;
            default: ;
         endcase
      end
   end
   assign apple  = vend_lines[0];
   assign banana = vend_lines[1];
   assign carrot = vend_lines[2];
   assign date   = vend_lines[3];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_phase  = 0;     // 0 idle, 1 waiting for manager, 2 paying change
   int m_credit = 0;
   int m_prod   = 0;
   int m_wait   = 0;
   int m_reject = 0;
   int m_deny   = 0;
   int m_coins[$];       // change still to pay, in cents, in payout order

   function automatic int val_of(input int code);
      case (code)
         0: return 5;
         1: return 10;
         2: return 25;
         default: return 100;
      endcase
   endfunction

   function automatic int price_of(input int code);
      case (code)
         0: return 75;
         1: return 20;
         2: return 30;
         default: return 40;
      endcase
   endfunction

   function automatic int code_of_cents(input int c);
      if (c == 25) return 2;
      if (c == 10) return 1;
      return 0;
   endfunction

   task automatic plan_change();
      int rest;
      rest = m_credit;
      m_coins.delete();
      while (rest >= 25) begin m_coins.push_back(25); rest -= 25; end
      while (rest >= 10) begin m_coins.push_back(10); rest -= 10; end
      while (rest >= 5)  begin m_coins.push_back(5);  rest -= 5;  end
   endtask

   task automatic model_reset();
      m_phase = 0; m_credit = 0; m_prod = 0; m_wait = 0;
      m_reject = 0; m_deny = 0;
      m_coins.delete();
   endtask

   task automatic model_step();
      int want;
      m_reject = 0;
      m_deny   = 0;
      case (m_phase)
         0: begin
            if (refund_req) begin
               m_reject = int'(coin_valid);
               if (m_credit > 0) begin plan_change(); m_phase = 2; end
            end else if (buy_req) begin
               m_reject = int'(coin_valid);
               m_prod   = int'(product_sel);
               m_wait   = 0;
               m_phase  = 1;
            end else if (coin_valid) begin
               if (m_credit + val_of(int'(coin_type)) <= 200)
                  m_credit += val_of(int'(coin_type));
               else
                  m_reject = 1;
            end
         end
         1: begin
            m_reject = int'(coin_valid);
            want = 1 << m_prod;
            if (vend_lines != 4'b0000 || error) begin
               if (!error && int'(vend_lines) == want && m_credit >= price_of(m_prod)) begin
                  m_credit -= price_of(m_prod);
                  if (m_credit == 0) m_phase = 0;
                  else begin plan_change(); m_phase = 2; end
               end else begin
                  m_deny = 1; m_phase = 0;
               end
            end else begin
               m_wait++;
               if (m_wait == 16) begin m_deny = 1; m_phase = 0; end
            end
         end
         default: begin
            m_reject = int'(coin_valid);
            m_credit -= m_coins.pop_front();
            if (m_coins.size() == 0) m_phase = 0;
         end
      endcase
   endtask

   task automatic model_compare();
      chk("m_credit",  int'(credit),       m_credit);
      chk("m_buy",     int'(buy),          int'(m_phase == 1));
      chk("m_busy",    int'(busy),         int'(m_phase != 0));
      chk("m_product", int'(product),      m_prod);
      chk("m_reject",  int'(coin_reject),  m_reject);
      chk("m_deny",    int'(deny),         m_deny);
      chk("m_chg_vld", int'(change_valid), int'(m_phase == 2));
      chk("m_chg_coin", int'(change_coin),
          (m_phase == 2) ? code_of_cents(m_coins[0]) : 0);
   endtask

   // Mid-cycle: compare against model, then advance it with the inputs that
   // the coming rising edge will sample.
   always @(negedge clk) begin
      if (reset) model_reset();
      if (chk_en) model_compare();
      if (!reset) model_step();
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic coin(input logic [1:0] t);
      coin_valid = 1'b1;
      coin_type  = t;
      cyc();
      coin_valid = 1'b0;
   endtask

   task automatic request_buy(input logic [1:0] p);
      buy_req     = 1'b1;
      product_sel = p;
      cyc();
      buy_req     = 1'b0;
   endtask

   int cnt;
   int rej_seen;

   initial begin
      reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; buy_req = 1'b0;
      product_sel = 2'b00; refund_req = 1'b0;
      cyc(); cyc();
      chk("rst_credit", int'(credit), 0);
      chk("rst_busy",   int'(busy), 0);
      chk("rst_chg",    int'(change_valid), 0);
      reset = 1'b0;
      chk_en = 1'b1;

      // 1: dollar, apple vended, one quarter back
      coin(2'b11);
      chk("t1_credit100", int'(credit), 100);
      resp_mode = 1;
      request_buy(2'b00);
      chk("t1_buy", int'(buy), 1);
      cyc();
      chk("t1_credit25", int'(credit), 25);
      chk("t1_chg_vld", int'(change_valid), 1);
      chk("t1_chg_coin", int'(change_coin), 2);
      cyc();
      chk("t1_credit0", int'(credit), 0);
      chk("t1_idle_vld", int'(change_valid), 0);
      chk("t1_busy", int'(busy), 0);
      resp_mode = 0;

      // 2: dime, apple, manager reports error
      coin(2'b01);
      resp_mode = 2;
      request_buy(2'b00);
      cyc();
      chk("t2_deny", int'(deny), 1);
      chk("t2_credit", int'(credit), 10);
      chk("t2_buy_drop", int'(buy), 0);
      cyc();
      chk("t2_deny_pulse", int'(deny), 0);
      resp_mode = 0;

      // 3: overflow reject at 200, then coin losing to buy_req
      do_reset();
      coin(2'b11);
      coin(2'b11);
      chk("t3_credit200", int'(credit), 200);
      coin(2'b00);
      chk("t3_reject", int'(coin_reject), 1);
      chk("t3_credit_kept", int'(credit), 200);
      resp_mode = 1;
      coin_valid = 1'b1; coin_type = 2'b01;
      request_buy(2'b01);
      coin_valid = 1'b0;
      chk("t3_buy", int'(buy), 1);
      chk("t3_lost_coin", int'(coin_reject), 1);
      chk("t3_product", int'(product), 1);
      cyc();
      chk("t3_credit180", int'(credit), 180);
      resp_mode = 0;
      for (int i = 0; i < 20 && busy; i++) cyc();
      chk("t3_done_busy", int'(busy), 0);
      chk("t3_done_credit", int'(credit), 0);

      // 4: refund of 45 -> quarter, dime, dime
      coin(2'b10); coin(2'b01); coin(2'b01);
      chk("t4_credit45", int'(credit), 45);
      refund_req = 1'b1;
      cyc();
      refund_req = 1'b0;
      chk("t4_c1", int'(change_coin), 2);
      chk("t4_cr1", int'(credit), 45);
      cyc();
      chk("t4_c2", int'(change_coin), 1);
      chk("t4_cr2", int'(credit), 20);
      cyc();
      chk("t4_c3", int'(change_coin), 1);
      chk("t4_cr3", int'(credit), 10);
      cyc();
      chk("t4_end_credit", int'(credit), 0);
      chk("t4_end_vld", int'(change_valid), 0);
      chk("t4_end_busy", int'(busy), 0);

      // 4b: wrong vend line is a failure; correct one leaves a nickel
      coin(2'b10);
      resp_mode = 3;
      request_buy(2'b01);
      cyc();
      chk("t4b_deny", int'(deny), 1);
      chk("t4b_credit", int'(credit), 25);
      resp_mode = 1;
      request_buy(2'b01);
      cyc();
      chk("t4b_credit5", int'(credit), 5);
      chk("t4b_nickel", int'(change_coin), 0);
      chk("t4b_vld", int'(change_valid), 1);
      cyc();
      resp_mode = 0;

      // 5: silent manager -> 16 buy cycles then deny; coin during BUY rejected
      do_reset();
      coin(2'b01);
      request_buy(2'b10);
      cnt = 0;
      rej_seen = 0;
      for (int i = 0; i < 40 && buy; i++) begin
         cnt++;
         coin_valid = (i == 2);
         coin_type  = 2'b00;
         cyc();
         if (coin_reject) rej_seen++;
      end
      coin_valid = 1'b0;
      chk("t5_buy_cycles", cnt, 16);
      chk("t5_deny", int'(deny), 1);
      chk("t5_reject_seen", rej_seen, 1);
      chk("t5_credit", int'(credit), 10);
      cyc();

      // 6: async reset during change with 30 left
      do_reset();
      coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b00);
      chk("t6_credit80", int'(credit), 80);
      refund_req = 1'b1;
      cyc();
      refund_req = 1'b0;
      cyc();
      cyc();
      chk("t6_credit30", int'(credit), 30);
      reset = 1'b1;
      #1;
      chk("t6_rst_credit", int'(credit), 0);
      chk("t6_rst_vld", int'(change_valid), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_buy", int'(buy), 0);
      cyc();
      reset = 1'b0;
      rej_seen = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (change_valid) rej_seen++;
      end
      chk("t6_no_more_change", rej_seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
Upstream stage of the vending purchase manager. Accumulates inserted coins into a credit register and drives the manager's `credit`, `buy` and `product` inputs. It consumes the manager's one-hot vend/error response, deducts the item price on a successful vend, then returns remaining credit as change, one coin per cycle.

Parameters:
MAX_CREDIT, 200, highest credit (cents) accepted; a coin that would exceed it is rejected.
TIMEOUT, 16, cycles to wait in BUY for a vend/error response before aborting.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
coin_valid  in  1  one-cycle pulse: coin presented
coin_type  in  2  00 nickel (5), 01 dime (10), 10 quarter (25), 11 dollar (100)
buy_req  in  1  user purchase request pulse
product_sel  in  2  00 apple, 01 banana, 10 carrot, 11 date; sampled with buy_req
refund_req  in  1  user request to return all credit
apple, banana, carrot, date  in  1 each  vend response from purchase manager
error  in  1  insufficient-credit response from purchase manager
credit  out  8  current credit in cents, to purchase manager
buy  out  1  purchase strobe to purchase manager, high for the whole BUY state
product  out  2  latched product code, to purchase manager
coin_reject  out  1  one-cycle pulse: presented coin not accepted
deny  out  1  one-cycle pulse: purchase failed (error or timeout)
change_valid  out  1  high while a change coin is issued this cycle
change_coin  out  2  coin issued: 00 nickel, 01 dime, 10 quarter (11 never issued)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - credit, product, timeout counter all 0.
  - buy, coin_reject, deny, change_valid, change_coin, busy all 0.
  - Reset mid-BUY or mid-CHANGE drops pending change and credit.
- Request priority in IDLE, same cycle: refund_req > buy_req > coin_valid.
  - A coin that loses to refund_req or buy_req is rejected.
- IDLE, coin_valid:
  - If credit + value <= MAX_CREDIT: credit updates next cycle.
  - Otherwise: coin_reject=1 next cycle and credit is unchanged.
  - Sum is computed 9 bits wide; no wrap.
- IDLE, buy_req:
  - product <= product_sel; move to BUY.
  - buy=1 from the next cycle.
- IDLE, refund_req:
  - credit>0: move to CHANGE.
  - credit=0: ignored.
- coin_valid in any non-IDLE state: coin_reject pulse; credit unchanged.
- buy_req and refund_req outside IDLE: ignored.
- BUY:
  - buy=1; product and credit held stable.
  - The manager responds combinationally, so the response is sampled every BUY cycle.
  - Any of apple/banana/carrot/date high: credit <= credit - price(product); go to CHANGE, or to IDLE if the result is 0.
  - Prices: apple 75, banana 20, carrot 30, date 40.
  - If the asserted vend line mismatches product, treat it as error.
  - error high: deny pulse; credit unchanged; go to IDLE.
  - No response for TIMEOUT consecutive BUY cycles: deny pulse; go to IDLE.
  - buy drops in the cycle after leaving BUY.
- CHANGE:
  - Each cycle, issue the largest coin <= credit: quarter, then dime, then nickel.
  - Outputs change_valid=1 and change_coin; credit decreases by that coin's value on the same edge.
  - When credit reaches 0, go to IDLE. change_valid is 0 in the IDLE cycle.
  - A residual below 5 cannot occur (all values are multiples of 5). If it does, clear credit and go to IDLE.
- Outputs are registered. credit is reported directly from the credit register.

Decomposition:
- Shared package vend_pkg:
  - coin encodings and values (5/10/25/100);
  - product encodings and prices (75/20/30/40);
  - state enum IDLE/BUY/CHANGE;
  - change-coin encoding.
- One natural sub-module: vend_change_sel.
  - Combinational; credit in, change_coin and coin value out, using the greedy quarter/dime/nickel choice.

Test Plan:
1. Insert dollar, buy_req apple, model responds apple=1 → credit 100→25, then one quarter (change_valid for 1 cycle), credit 0, back to IDLE.
2. Insert dime, buy_req apple, model responds error=1 → deny pulse, credit stays 10, buy drops next cycle.
3. Two dollars (credit 200), then nickel → coin_reject pulse, credit stays 200. Same-cycle coin+buy_req → coin rejected, BUY entered.
4. Credit 45, refund_req → quarter, dime, dime on 3 consecutive cycles; credit 45→20→10→0; busy low after.
5. buy_req with no response → buy high exactly 16 cycles, then deny pulse and IDLE; coin during BUY → coin_reject.
6. Assert reset during CHANGE with 30 remaining → all outputs 0 immediately (async), IDLE; no further change coins after release.
